ysyx_24120013_idu_stage: RTL
============================

// Module: ysyx_24120013_idu_stage
// PURPOSE
//  Registered RV32I decode stage between IFU and EXU. Accepts {pc,inst} with valid/ready.
//  Drives regfile read addresses combinationally from the incoming inst and captures rdata1/2 on accept.
//  Decodes all six immediate formats, a command code and an illegal flag into an output register, with flush support.
// PARAMETERS
//  COMMAND_WIDTH  4   width of IDU_command; must be >= 4
//  ADDR_WIDTH     5   regfile address width (4 for RV32E, upper inst bit dropped)
//  DATA_WIDTH     32  register and immediate width; must be >= 32
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous active-high reset
//  flush         in   1              drop all held entries (branch redirect)
//  in_valid      in   1              upstream {in_pc,inst} valid
//  in_ready      out  1              stage can accept this cycle
//  in_pc         in   DATA_WIDTH     PC of inst
//  inst          in   32             instruction word
//  IDU_raddr1    out  ADDR_WIDTH     inst[15+:ADDR_WIDTH], combinational
//  IDU_raddr2    out  ADDR_WIDTH     inst[20+:ADDR_WIDTH], combinational
//  rdata1/rdata2 in   DATA_WIDTH     regfile async read data, same cycle as inst
//  out_valid     out  1              decoded bundle valid
//  out_ready     in   1              EXU accepts bundle
//  IDU_pc        out  DATA_WIDTH     registered PC
//  IDU_src1/src2 out  DATA_WIDTH     registered rdata1/rdata2
//  IDU_des       out  ADDR_WIDTH     rd; 0 for S/B types
//  IDU_imm       out  DATA_WIDTH     sign-extended immediate
//  IDU_imm_type  out  6              one-hot {J,U,B,S,I,R}; 0 if illegal
//  IDU_command   out  COMMAND_WIDTH  command code, zero-extended
//  IDU_illegal   out  1              unrecognised opcode
// BEHAVIOUR
//  Reset: out_valid=0; all bundle outputs 0; skid (if present) empty. in_ready=1 once rst deasserts.
//  Accept when in_valid&&in_ready; bundle registers load on the same edge (latency 1 cycle).
//  Transfer when out_valid&&out_ready; bundle regs hold their values while out_valid&&!out_ready.
//  in_ready (base build) = !flush && (!out_valid || out_ready): one entry, full throughput.
//  Opcode -> command/type: 0010011 OP-IMM 1/I; 0110011 OP 2/R; 0110111 LUI 3/U; 0010111 AUIPC 4/U;
//   1101111 JAL 5/J; 1100111 JALR 6/I; 1100011 BRANCH 7/B; 0000011 LOAD 8/I; 0100011 STORE 9/S;
//   1110011 SYSTEM 10/I; any other opcode: command 0, imm_type 0, imm 0, IDU_illegal=1.
//  Imm: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0};
//   U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; R 0; sign-extend from bit 31 to DATA_WIDTH.
//  Illegal bundles still flow downstream (EXU traps); illegal never stalls the stage.
//  Flush: on the edge where flush=1, out_valid<=0 and skid is emptied; in_ready=0 that cycle, so no accept.
//  Flush with out_valid&&out_ready in the same cycle: transfer counts, then entry cleared.
//  rst during a held stall: bundle discarded, outputs return to reset values next edge.
// CONFIGURATION
//  IDU_SKID_BUF_EN defined: adds a 1-entry skid register; in_ready = !flush && skid empty (registered,
//   no combinational path from out_ready). Accept while output full and stalled fills the skid;
//   the skid drains to output on the next transfer. Throughput stays 1/cycle; latency stays 1 cycle.
//  Undefined: no skid; in_ready combinational on out_ready as above.
// TESTING
//  addi x1,x2,-1 (0xFFF10093), rdata1=5 -> 1 cycle later out_valid=1, cmd=1, imm=0xFFFFFFFF, des=1, src1=5, type=I.
//  sw x3,-4(x2) (0xFE312E23) -> cmd=9, imm=0xFFFFFFFC, des=0, type=S; beq x0,x0,-8 (0xFE000CE3) -> cmd=7, imm=0xFFFFFFF8.
//  jal x1,+2048 (0x001000EF) -> cmd=5, imm=0x00000800; lui x5,0x12345 (0x123452B7) -> imm=0x12345000.
//  inst=0xFFFFFFFF -> IDU_illegal=1, cmd=0, imm=0, out_valid=1, stage not stalled.
//  Hold out_ready=0 for 3 cycles with in_valid=1 -> bundle stable; base: in_ready=0; SKID_EN: one extra accept, then in_ready=0; release -> both in order.
//  Assert flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not accepted; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/ysyx_24120013_idu_stage.sv
// ysyx_24120013_idu_stage: registered RV32I decode stage between IFU and EXU.
// Define IDU_SKID_BUF_EN to add a one-entry skid register that takes out_ready off the in_ready path.
module ysyx_24120013_idu_stage #(
    parameter int COMMAND_WIDTH = 4,
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [31:0]              inst,
    output logic [ADDR_WIDTH-1:0]    IDU_raddr1,
    output logic [ADDR_WIDTH-1:0]    IDU_raddr2,
    input  logic [DATA_WIDTH-1:0]    rdata1,
    input  logic [DATA_WIDTH-1:0]    rdata2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    IDU_pc,
    output logic [DATA_WIDTH-1:0]    IDU_src1,
    output logic [DATA_WIDTH-1:0]    IDU_src2,
    output logic [ADDR_WIDTH-1:0]    IDU_des,
    output logic [DATA_WIDTH-1:0]    IDU_imm,
    output logic [5:0]               IDU_imm_type,
    output logic [COMMAND_WIDTH-1:0] IDU_command,
    output logic                     IDU_illegal
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // One-hot immediate format, bit order {J,U,B,S,I,R}
    localparam logic [5:0] TYPE_R = 6'b000001;
    localparam logic [5:0] TYPE_I = 6'b000010;
    localparam logic [5:0] TYPE_S = 6'b000100;
    localparam logic [5:0] TYPE_B = 6'b001000;
    localparam logic [5:0] TYPE_U = 6'b010000;
    localparam logic [5:0] TYPE_J = 6'b100000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    pc;
        logic [DATA_WIDTH-1:0]    src1;
        logic [DATA_WIDTH-1:0]    src2;
        logic [ADDR_WIDTH-1:0]    des;
        logic [DATA_WIDTH-1:0]    imm;
        logic [5:0]               imm_type;
        logic [COMMAND_WIDTH-1:0] command;
        logic                     illegal;
    } bundle_t;

    function automatic logic [COMMAND_WIDTH-1:0] cmd_code(input logic [3:0] c);
        return COMMAND_WIDTH'(c);
    endfunction

    function automatic logic signed [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic bundle_t decode(input logic [31:0]           i,
                                       input logic [DATA_WIDTH-1:0] pc,
                                       input logic [DATA_WIDTH-1:0] r1,
                                       input logic [DATA_WIDTH-1:0] r2);
        bundle_t                      b;
        logic signed [31:0]           imm32;
        logic signed [DATA_WIDTH-1:0] imm_ext;
        b       = '0;
        imm32   = '0;
        b.pc    = pc;
        b.src1  = r1;
        b.src2  = r2;
        b.des   = i[7 +: ADDR_WIDTH];
        case (i[6:0])
            OPC_OP_IMM: begin b.command = cmd_code(4'd1);  b.imm_type = TYPE_I; imm32 = imm_i(i); end
            OPC_OP:     begin b.command = cmd_code(4'd2);  b.imm_type = TYPE_R; end
            OPC_LUI:    begin b.command = cmd_code(4'd3);  b.imm_type = TYPE_U; imm32 = imm_u(i); end
            OPC_AUIPC:  begin b.command = cmd_code(4'd4);  b.imm_type = TYPE_U; imm32 = imm_u(i); end
            OPC_JAL:    begin b.command = cmd_code(4'd5);  b.imm_type = TYPE_J; imm32 = imm_j(i); end
            OPC_JALR:   begin b.command = cmd_code(4'd6);  b.imm_type = TYPE_I; imm32 = imm_i(i); end
            OPC_BRANCH: begin b.command = cmd_code(4'd7);  b.imm_type = TYPE_B; imm32 = imm_b(i); end
            OPC_LOAD:   begin b.command = cmd_code(4'd8);  b.imm_type = TYPE_I; imm32 = imm_i(i); end
            OPC_STORE:  begin b.command = cmd_code(4'd9);  b.imm_type = TYPE_S; imm32 = imm_s(i); end
            OPC_SYSTEM: begin b.command = cmd_code(4'd10); b.imm_type = TYPE_I; imm32 = imm_i(i); end
            default:    b.illegal = 1'b1;
        endcase
        // Stores and branches have no destination; the rd field holds immediate bits
        if (b.imm_type == TYPE_S || b.imm_type == TYPE_B) begin
            b.des = '0;
        end
        imm_ext = imm32;
        b.imm   = imm_ext;
        return b;
    endfunction

    bundle_t in_bundle;
    bundle_t out_p1;
    logic    out_vld_p1;
    logic    accept;
    logic    xfer;

    assign IDU_raddr1 = inst[15 +: ADDR_WIDTH];
    assign IDU_raddr2 = inst[20 +: ADDR_WIDTH];
    assign in_bundle  = decode(inst, in_pc, rdata1, rdata2);
    assign accept     = in_valid && in_ready;
    assign xfer       = out_vld_p1 && out_ready;

`ifdef IDU_SKID_BUF_EN
    bundle_t skid_p1;
    logic    skid_vld_p1;

    assign in_ready = !flush && !skid_vld_p1;

    // p0 -> p1: output register, refilled from the skid before taking new input
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_p1  <= 1'b0;
            out_p1      <= '0;
            skid_vld_p1 <= 1'b0;
            skid_p1     <= '0;
        end else if (flush) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!out_vld_p1 || xfer) begin
            if (skid_vld_p1) begin
                out_p1      <= skid_p1;
                out_vld_p1  <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (accept) begin
                out_p1     <= in_bundle;
                out_vld_p1 <= 1'b1;
            end else begin
                out_vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_p1     <= in_bundle;
            skid_vld_p1 <= 1'b1;
        end
    end
`else
    assign in_ready = !flush && (!out_vld_p1 || out_ready);

    // p0 -> p1: single output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_p1 <= 1'b0;
            out_p1     <= '0;
        end else if (flush) begin
            out_vld_p1 <= 1'b0;
        end else if (accept) begin
            out_vld_p1 <= 1'b1;
            out_p1     <= in_bundle;
        end else if (xfer) begin
            out_vld_p1 <= 1'b0;
        end
    end
`endif

    assign out_valid    = out_vld_p1;
    assign IDU_pc       = out_p1.pc;
    assign IDU_src1     = out_p1.src1;
    assign IDU_src2     = out_p1.src2;
    assign IDU_des      = out_p1.des;
    assign IDU_imm      = out_p1.imm;
    assign IDU_imm_type = out_p1.imm_type;
    assign IDU_command  = out_p1.command;
    assign IDU_illegal  = out_p1.illegal;

endmodule
